// File: rtl/root_pkg.sv
// Shared widths and FSM encoding for the Root job dispatcher.
package root_pkg;

  localparam int BASE_W  = 10;
  localparam int EXP_W   = 3;
  localparam int FRAC_W  = 10;
  localparam int RES_W   = BASE_W + FRAC_W;
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/root_req_fifo.sv
// Synchronous request FIFO of {tag, exp, base}. The head is shown combinationally.
// The full flag comes from the registered count, so a pop in the same cycle does not free a slot.
module root_req_fifo
  import root_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = BASE_W + EXP_W + 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // pointer and occupancy bookkeeping; pointers wrap at DEPTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // storage write; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/root_job_dispatcher.sv
// Root job dispatcher: queues n-th root requests and runs them through the Root engine
// one at a time. It returns each tagged 10.10 result on a valid/ready port.
//
// state | meaning
// IDLE  | wait for a queued request while the Root strobe is low
// ISSUE | one-cycle start pulse to Root; clear the timer
// WAIT  | count cycles until Root answers or the timeout expires
// DRAIN | show the error response; wait for the handshake and the late Root strobe
// RESP  | show the result; on handshake pop the request and return to IDLE
module root_job_dispatcher
  import root_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [BASE_W-1:0] req_base,
  input  logic [EXP_W-1:0]  req_exp,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_err,
  output logic              root_in_valid,
  output logic [BASE_W-1:0] root_in_data_1,
  output logic [EXP_W-1:0]  root_in_data_2,
  input  logic              root_out_valid,
  input  logic [RES_W-1:0]  root_out_data,
  output logic              busy
);

  localparam int ENT_W = TAG_W + EXP_W + BASE_W;

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer;
  logic               ov_q, ov_rise;
  logic               rsp_done, ov_seen;
  logic               full, empty, push, pop, hs;
  logic [ENT_W-1:0]   head;
  logic [TAG_W-1:0]   head_tag;
  logic [EXP_W-1:0]   head_exp;
  logic [BASE_W-1:0]  head_base;
  logic               timed_out;

  assign {head_tag, head_exp, head_base} = head;
  assign req_ready      = ~full;
  assign push           = req_valid & req_ready;
  assign hs             = rsp_valid & rsp_ready;
  assign ov_rise        = root_out_valid & ~ov_q;
  assign timed_out      = (timer == TIMER_W'(TIMEOUT));
  assign root_in_valid  = (state == ST_ISSUE);
  assign root_in_data_1 = head_base;
  assign root_in_data_2 = head_exp;
  assign busy           = (state != ST_IDLE) | ~empty;

  root_req_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({req_tag, req_exp, req_base}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // next-state and pop decode
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (head_exp == '0)       state_n = ST_RESP;
          else if (!root_out_valid) state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (ov_rise)        state_n = ST_RESP;
        else if (timed_out) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // the timed-out job leaves the queue as soon as its error response is accepted
        pop = hs;
        if ((rsp_done | hs) & (ov_seen | ov_rise)) state_n = ST_IDLE;
      end
      ST_RESP: begin
        if (hs) begin
          pop     = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // state, timer, strobe edge detect and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      ov_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      rsp_done  <= 1'b0;
      ov_seen   <= 1'b0;
    end else begin
      state <= state_n;
      ov_q  <= root_out_valid;
      case (state)
        ST_IDLE: begin
          if (!empty && head_exp == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_tag   <= head_tag;
          end
        end
        ST_ISSUE: timer <= '0;
        ST_WAIT: begin
          if (timer != '1) timer <= timer + 1'b1;
          rsp_done <= 1'b0;
          ov_seen  <= 1'b0;
          if (ov_rise) begin
            rsp_valid <= 1'b1;
            rsp_data  <= root_out_data;
            rsp_err   <= 1'b0;
            rsp_tag   <= head_tag;
          end else if (timed_out) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_tag   <= head_tag;
          end
        end
        ST_DRAIN: begin
          if (hs) rsp_valid <= 1'b0;
          if (state_n == ST_IDLE) begin
            rsp_done <= 1'b0;
            ov_seen  <= 1'b0;
          end else begin
            rsp_done <= rsp_done | hs;
            ov_seen  <= ov_seen | ov_rise;
          end
        end
        ST_RESP: begin
          if (hs) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_root_job_dispatcher.sv
// Bench for root_job_dispatcher. A behavioural Root stub answers after a set latency with
// floor(base^(1/n)) in 10.10 fixed point. A queue of expected responses is built from
// the request stream.
module tb_root_job_dispatcher;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 255;

  typedef struct packed {
    logic [19:0]      d;
    logic [TAG_W-1:0] t;
    logic             e;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [9:0]       req_base = '0;
  logic [2:0]       req_exp = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             rsp_ready = 1'b0;
  logic             root_out_valid = 1'b0;
  logic [19:0]      root_out_data = '0;
  logic             req_ready, rsp_valid, rsp_err, root_in_valid, busy;
  logic [19:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [9:0]       root_in_data_1;
  logic [2:0]       root_in_data_2;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  rsp_t exp_q[$];
  rsp_t obs_q[$];

  // stub control and bookkeeping
  int         stub_lat = 3;
  int         stub_mute_cnt = 0;
  bit         stub_late = 0;
  bit         stub_rand = 0;
  int         stub_cnt = 0;
  int         stub_hold = 0;
  logic [9:0] cap_b = '0;
  logic [2:0] cap_e = '0;
  int         issue_cnt = 0;
  int         issue_cyc = 0;
  int         opnd_viol = 0;
  int         hold_viol = 0;
  bit         prev_wait = 0;
  rsp_t       prev_rsp = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  root_job_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_base       (req_base),
    .req_exp        (req_exp),
    .req_tag        (req_tag),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_tag        (rsp_tag),
    .rsp_err        (rsp_err),
    .root_in_valid  (root_in_valid),
    .root_in_data_1 (root_in_data_1),
    .root_in_data_2 (root_in_data_2),
    .root_out_valid (root_out_valid),
    .root_out_data  (root_out_data),
    .busy           (busy)
  );

  // largest r with r^n <= base * 1024^n, i.e. the floor of the 10.10 root
  function automatic logic [19:0] root_fx(input logic [9:0] b, input logic [2:0] n);
    logic [159:0] tgt, p;
    int lo, hi, mid;
    if (n == 0) return 20'd0;
    tgt = 160'(b) << (10 * int'(n));
    lo = 0;
    hi = (1 << 20) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      p = 160'd1;
      for (int i = 0; i < int'(n); i++) p = p * 160'(mid);
      if (p <= tgt) lo = mid; else hi = mid - 1;
    end
    return 20'(lo);
  endfunction

  function automatic rsp_t model(input logic [9:0] b, input logic [2:0] e, input logic [TAG_W-1:0] t, input bit to);
    rsp_t r;
    r.t = t;
    if (e == 0 || to) begin r.d = 20'd0; r.e = 1'b1; end
    else begin r.d = root_fx(b, e); r.e = 1'b0; end
    return r;
  endfunction

  // Root stub: latency countdown, 1-2 cycle result strobe, operand stability watch
  always @(negedge clk) begin
    if (!rst_n) begin
      root_out_valid = 1'b0;
      stub_cnt = 0;
      stub_hold = 0;
    end else begin
      if (stub_hold > 0) begin
        stub_hold--;
        if (stub_hold == 0) root_out_valid = 1'b0;
      end
      if (stub_cnt > 0) begin
        if (root_in_data_1 !== cap_b || root_in_data_2 !== cap_e) opnd_viol++;
        stub_cnt--;
        if (stub_cnt == 0) begin
          root_out_valid = 1'b1;
          root_out_data = root_fx(cap_b, cap_e);
          stub_hold = stub_rand ? int'($urandom_range(1, 2)) : 2;
        end
      end
      if (stub_late) begin
        stub_late = 0;
        root_out_valid = 1'b1;
        root_out_data = 20'hABCDE;
        stub_hold = 2;
      end
      if (root_in_valid) begin
        issue_cnt++;
        issue_cyc = cyc;
        cap_b = root_in_data_1;
        cap_e = root_in_data_2;
        if (stub_mute_cnt > 0) stub_mute_cnt--;
        else stub_cnt = stub_rand ? int'($urandom_range(1, 15)) : stub_lat;
      end
    end
  end

  // response monitor: records handshakes and watches hold stability
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (prev_wait && rsp_t'({rsp_data, rsp_tag, rsp_err}) !== prev_rsp) hold_viol++;
      if (rsp_ready) obs_q.push_back(rsp_t'({rsp_data, rsp_tag, rsp_err}));
    end
    prev_wait = rst_n && rsp_valid && !rsp_ready;
    prev_rsp = rsp_t'({rsp_data, rsp_tag, rsp_err});
  end

  // entered and left just after a rising edge
  task automatic send(input logic [9:0] b, input logic [2:0] e, input logic [TAG_W-1:0] t,
                      input bit to, input int attempts, output int pc, output bit acc);
    int n = 0;
    req_valid = 1'b1; req_base = b; req_exp = e; req_tag = t;
    acc = 0;
    while (!acc && n < attempts) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk); #1;
      n++;
    end
    pc = cyc;
    req_valid = 1'b0;
    if (acc) exp_q.push_back(model(b, e, t, to));
  endtask

  task automatic wait_obs(input int n, input int bound, output bit ok);
    int k = 0;
    while (obs_q.size() < n && k < bound) begin @(posedge clk); #1; k++; end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    tests_run++; if (rsp_data !== 20'd0) begin tests_failed++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    tests_run++; if (rsp_tag !== '0) begin tests_failed++; $display("FAIL reset_rsp_tag: got %h want 0", rsp_tag); end
    tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    tests_run++; if (root_in_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_root_in_valid: got %b want 0", root_in_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int pc, ic0; bit acc, ok; rsp_t o, x;
    rsp_ready = 1'b1; stub_lat = 3; ic0 = issue_cnt;
    send(10'd27, 3'd3, 4'd1, 0, 50, pc, acc);
    wait_obs(1, 200, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_timeout: got %0d responses want 1", obs_q.size()); end
    tests_run++; if (issue_cnt - ic0 !== 1) begin tests_failed++; $display("FAIL single_issue_count: got %0d want 1", issue_cnt - ic0); end
    tests_run++; if (issue_cyc !== pc + 1) begin tests_failed++; $display("FAIL single_issue_latency: got %0d want %0d", issue_cyc, pc + 1); end
    x = exp_q.size() > 0 ? exp_q[0] : '0;
    tests_run++; if (x.d !== 20'h00C00) begin tests_failed++; $display("FAIL single_model: got %h want 00c00", x.d); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL single_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
  endtask

  task automatic test_back_to_back;
    int pc, ic0; bit acc, ok; rsp_t o, x;
    rsp_ready = 1'b1; stub_lat = 4; ic0 = issue_cnt; opnd_viol = 0;
    send(10'd16, 3'd2, 4'd2, 0, 50, pc, acc);
    send(10'd5, 3'd1, 4'd4, 0, 50, pc, acc);
    wait_obs(2, 200, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL b2b_timeout: got %0d responses want 2", obs_q.size()); end
    tests_run++; if (issue_cnt - ic0 !== 2) begin tests_failed++; $display("FAIL b2b_issue_count: got %0d want 2", issue_cnt - ic0); end
    tests_run++; if (opnd_viol !== 0) begin tests_failed++; $display("FAIL b2b_operands: got %0d changes want 0", opnd_viol); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL b2b_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
  endtask

  task automatic test_exp_zero;
    int pc, ic0, n; bit acc, ok; rsp_t o, x;
    rsp_ready = 1'b0; ic0 = issue_cnt;
    send(10'd9, 3'd0, 4'd3, 0, 50, pc, acc);
    n = 0;
    while (n < 3) begin @(negedge clk); n++; if (rsp_valid) break; end
    tests_run++; if (rsp_valid !== 1'b1) begin tests_failed++; $display("FAIL exp0_latency: got rsp_valid=%b want 1 within 3 cycles", rsp_valid); end
    tests_run++; if ({rsp_err, rsp_data} !== {1'b1, 20'd0}) begin tests_failed++; $display("FAIL exp0_err: got err=%b d=%h want err=1 d=0", rsp_err, rsp_data); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_obs(1, 50, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL exp0_timeout: got %0d responses want 1", obs_q.size()); end
    tests_run++; if (issue_cnt !== ic0) begin tests_failed++; $display("FAIL exp0_no_issue: got %0d issues want 0", issue_cnt - ic0); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL exp0_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
  endtask

  task automatic test_full;
    int pc; bit acc, ok; rsp_t o, x;
    rsp_ready = 1'b0; stub_lat = 3;
    for (int i = 0; i <= DEPTH; i++) begin
      send(10'(i * 50 + 10), 3'(i % 3 + 1), TAG_W'(i + 8), 0, (i < DEPTH) ? 50 : 3, pc, acc);
      tests_run++;
      if (acc !== (i < DEPTH)) begin tests_failed++; $display("FAIL full_accept_%0d: got %b want %b", i, acc, i < DEPTH); end
    end
    @(negedge clk);
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL full_req_ready: got %b want 0", req_ready); end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_obs(DEPTH, 500, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL full_timeout: got %0d responses want %0d", obs_q.size(), DEPTH); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL full_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({req_ready, busy} !== 2'b10) begin tests_failed++; $display("FAIL full_recover: got ready=%b busy=%b want ready=1 busy=0", req_ready, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout;
    int pc, ic0, n; bit acc, ok; rsp_t o, x;
    rsp_ready = 1'b1; stub_lat = 3; stub_mute_cnt = 1; ic0 = issue_cnt;
    send(10'd8, 3'd3, 4'd5, 1, 50, pc, acc);
    n = 0;
    while (n < 400) begin @(negedge clk); n++; if (rsp_valid) break; end
    tests_run++; if (cyc - issue_cyc !== TIMEOUT + 2) begin tests_failed++; $display("FAIL timeout_latency: got %0d cycles want %0d", cyc - issue_cyc, TIMEOUT + 2); end
    tests_run++; if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 20'd0}) begin tests_failed++; $display("FAIL timeout_err: got v=%b err=%b d=%h want v=1 err=1 d=0", rsp_valid, rsp_err, rsp_data); end
    @(posedge clk); #1;
    send(10'd8, 3'd3, 4'd6, 0, 50, pc, acc);
    repeat (5) @(posedge clk);
    @(negedge clk);
    tests_run++; if ({busy, 32'(issue_cnt - ic0)} !== {1'b1, 32'd1}) begin tests_failed++; $display("FAIL drain_hold: got busy=%b issues=%0d want busy=1 issues=1", busy, issue_cnt - ic0); end
    @(posedge clk); #1;
    stub_late = 1;
    wait_obs(2, 100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_next_timeout: got %0d responses want 2", obs_q.size()); end
    tests_run++; if (issue_cnt - ic0 !== 2) begin tests_failed++; $display("FAIL timeout_issue_count: got %0d want 2", issue_cnt - ic0); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL timeout_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
  endtask

  task automatic test_mid_reset;
    int pc, ic0; bit acc, ok, seen; rsp_t o, x;
    rsp_ready = 1'b1; stub_lat = 60;
    for (int i = 0; i < 4; i++) send(10'(100 + i), 3'd2, TAG_W'(i + 1), 0, 50, pc, acc);
    repeat (10) @(posedge clk);
    #1;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mreset_busy_before: got %b want 1", busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_err, root_in_valid, busy, req_ready} !== {1'b0, 20'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mreset_outputs: got v=%b d=%h t=%h e=%b iv=%b busy=%b rdy=%b want all 0, rdy=1",
               rsp_valid, rsp_data, rsp_tag, rsp_err, root_in_valid, busy, req_ready);
    end
    exp_q.delete(); obs_q.delete();
    ic0 = issue_cnt; seen = 0;
    for (int i = 0; i < 80; i++) begin @(negedge clk); if (rsp_valid) seen = 1; end
    @(posedge clk); #1;
    tests_run++; if ({seen, 32'(issue_cnt - ic0)} !== {1'b0, 32'd0}) begin tests_failed++; $display("FAIL mreset_stale: got rsp_seen=%b issues=%0d want 0 0", seen, issue_cnt - ic0); end
    stub_lat = 3;
    send(10'd100, 3'd2, 4'd9, 0, 50, pc, acc);
    wait_obs(1, 100, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL mreset_timeout: got %0d responses want 1", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL mreset_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
  endtask

  task automatic test_random;
    localparam int N = 40;
    int nacc, nexp, ic0; bit prod_done; rsp_t o, x;
    stub_rand = 1; nacc = 0; nexp = 0; prod_done = 0; ic0 = issue_cnt;
    opnd_viol = 0; hold_viol = 0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          int pc; bit acc; logic [2:0] e;
          e = 3'($urandom);
          send(10'($urandom), e, TAG_W'($urandom), 0, 500, pc, acc);
          if (acc) begin nacc++; if (e != 0) nexp++; end
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        prod_done = 1;
      end
      begin
        int k = 0;
        while (!(prod_done && obs_q.size() >= nacc) && k < 20000) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
          k++;
        end
        rsp_ready = 1'b1;
      end
    join
    stub_rand = 0;
    tests_run++; if (nacc !== N) begin tests_failed++; $display("FAIL rand_accepted: got %0d want %0d", nacc, N); end
    tests_run++; if (obs_q.size() !== exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d responses want %0d", obs_q.size(), exp_q.size()); end
    tests_run++; if (issue_cnt - ic0 !== nexp) begin tests_failed++; $display("FAIL rand_issue_count: got %0d want %0d", issue_cnt - ic0, nexp); end
    tests_run++; if ({opnd_viol, hold_viol} !== 64'd0) begin tests_failed++; $display("FAIL rand_stability: got operand=%0d hold=%0d want 0 0", opnd_viol, hold_viol); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); x = exp_q.pop_front();
      tests_run++;
      if (o !== x) begin tests_failed++; $display("FAIL rand_rsp: got d=%h tag=%h err=%b want d=%h tag=%h err=%b", o.d, o.t, o.e, x.d, x.t, x.e); end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_exp_zero();
    test_full();
    test_timeout();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
